// File: rtl/rr_arbiter_if.sv
// Request/grant bundle between N requesters and the round-robin arbiter.
interface rr_arbiter_if #(
    parameter int N = 4
);
    localparam int IW = $clog2(N);

    logic [N-1:0]  req;
    logic [N-1:0]  grant;
    logic          grant_valid;
    logic [IW-1:0] grant_idx;

    // Requester side drives req and watches the grant.
    modport master (
        output req,
        input  grant,
        input  grant_valid,
        input  grant_idx
    );

    // Arbiter side samples req and owns the registered grant outputs.
    modport slave (
        input  req,
        output grant,
        output grant_valid,
        output grant_idx
    );
endinterface

// File: rtl/rr_arbiter.sv
// N-way round-robin arbiter with sticky grants and an optional hold limit.
// The owner keeps its grant while requesting; MAX_HOLD>0 forces a hand-off
// to a waiting requester after MAX_HOLD consecutive owned cycles.
module rr_arbiter #(
    parameter int N        = 4,
    parameter int MAX_HOLD = 0
) (
    input  logic        clock,
    input  logic        reset,
    rr_arbiter_if.slave bus
);
    localparam int IW = $clog2(N);

    logic [N-1:0]  grant_q;
    logic [IW-1:0] idx_q;
    logic          valid_q;
    logic [IW-1:0] last_q;

    logic          hit;
    logic [IW-1:0] pick;
    logic          owned;
    logic          owner_req;
    logic          hold_hit;
    logic          take_new;
    logic          go_idle;

    // Circular first-set search starting just after base; returns {found, index}.
    function automatic logic [IW:0] rr_search(input logic [N-1:0] v,
                                              input logic [IW-1:0] base);
        logic [2*N-1:0] dbl;
        logic [N-1:0]   rot;
        logic           found;
        logic [IW-1:0]  idx;
        int             s;
        int             j;
        s = int'(base) + 1;
        if (s >= N) s = 0;
        dbl   = {v, v};
        rot   = N'(dbl >> s);
        found = 1'b0;
        idx   = '0;
        j     = 0;
        for (int k = 0; k < N; k++) begin
            if (!found && rot[k]) begin
                found = 1'b1;
                j = s + k;
                if (j >= N) j = j - N;
                idx = IW'(j);
            end
        end
        return {found, idx};
    endfunction

    // Pick the next requester and decide between new grant, release to idle, or keep.
    // While owned, last_q always equals the owner index, so one search from last_q
    // serves idle, release and preempt; masking the owner out covers preemption.
    always_comb begin
        {hit, pick} = rr_search(bus.req & ~grant_q, last_q);
        owned       = |grant_q;
        owner_req   = |(bus.req & grant_q);
        take_new    = 1'b0;
        go_idle     = 1'b0;
        if (!owned) begin
            take_new = hit;
        end else if (!owner_req) begin
            take_new = hit;
            go_idle  = !hit;
        end else begin
            take_new = hold_hit && hit;
        end
    end

    // Grant, index and pointer registers; a hand-off swaps owners on a single edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            grant_q <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            last_q  <= IW'(N - 1);
        end else if (take_new) begin
            grant_q <= {{(N-1){1'b0}}, 1'b1} << pick;
            idx_q   <= pick;
            valid_q <= 1'b1;
            last_q  <= pick;
        end else if (go_idle) begin
            grant_q <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
        end
    end

    generate
        if (MAX_HOLD > 0) begin : g_hold
            localparam int HW = $clog2(MAX_HOLD + 1);
            logic [HW-1:0] hold_cnt;

            // Count consecutive owned cycles: restart at 1 on a new grant, saturate at the limit.
            always_ff @(posedge clock) begin
                if (reset) begin
                    hold_cnt <= '0;
                end else if (take_new) begin
                    hold_cnt <= HW'(1);
                end else if (owner_req && !hold_hit) begin
                    hold_cnt <= hold_cnt + HW'(1);
                end
            end

            assign hold_hit = (hold_cnt == HW'(MAX_HOLD));
        end else begin : g_nohold
            assign hold_hit = 1'b0;
        end
    endgenerate

    assign bus.grant       = grant_q;
    assign bus.grant_valid = valid_q;
    assign bus.grant_idx   = idx_q;
endmodule

// File: tb/tb_rr_arbiter.sv
// Bench for rr_arbiter: three instances (N=4 sticky, N=4 hold=4, N=2 sticky),
// directed vector table plus random stimulus against a reference model.
module tb_rr_arbiter;
    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic            reset;
    logic [2:0][3:0] rq;
    logic [2:0][3:0] gv;
    logic [2:0]      vv;
    logic [2:0][1:0] iv;

    int errors = 0;
    int checks = 0;

    localparam int NN [3] = '{4, 4, 2};
    localparam int MH [3] = '{0, 4, 0};
    localparam int FAIR = (4 - 1) * 4 + 1;

    rr_arbiter_if #(.N(4)) bus0 ();
    rr_arbiter_if #(.N(4)) bus1 ();
    rr_arbiter_if #(.N(2)) bus2 ();

    rr_arbiter #(.N(4), .MAX_HOLD(0)) u0 (.clock(clock), .reset(reset), .bus(bus0));
    rr_arbiter #(.N(4), .MAX_HOLD(4)) u1 (.clock(clock), .reset(reset), .bus(bus1));
    rr_arbiter #(.N(2), .MAX_HOLD(0)) u2 (.clock(clock), .reset(reset), .bus(bus2));

    assign bus0.req = rq[0];
    assign bus1.req = rq[1];
    assign bus2.req = rq[2][1:0];

    assign gv[0] = bus0.grant;
    assign gv[1] = bus1.grant;
    assign gv[2] = {2'b00, bus2.grant};
    assign vv    = {bus2.grant_valid, bus1.grant_valid, bus0.grant_valid};
    assign iv[0] = bus0.grant_idx;
    assign iv[1] = bus1.grant_idx;
    assign iv[2] = {1'b0, bus2.grant_idx};

    // ---------------- reference model ----------------
    // Owner is an integer (-1 = nobody); searches walk the ring with modulo.
    int m_own [3];
    int m_last[3];
    int m_h   [3];

    function automatic int find_from(input logic [3:0] r, input int start,
                                     input int n, input int skip);
        for (int k = 0; k < n; k++) begin
            int i;
            i = (start + k) % n;
            if (i != skip && r[i]) return i;
        end
        return -1;
    endfunction

    // Advance the model on every edge using the requests the DUTs sample.
    always @(posedge clock) begin
        for (int d = 0; d < 3; d++) begin
            int own, last, h, w, n;
            n    = NN[d];
            own  = m_own[d];
            last = m_last[d];
            h    = m_h[d];
            if (reset) begin
                own = -1; last = n - 1; h = 0;
            end else if (own < 0) begin
                w = find_from(rq[d], last + 1, n, -1);
                if (w >= 0) begin own = w; last = w; h = 1; end
            end else if (!rq[d][own]) begin
                w = find_from(rq[d], own + 1, n, own);
                if (w >= 0) begin own = w; last = w; h = 1; end
                else begin last = own; own = -1; end
            end else begin
                w = find_from(rq[d], own + 1, n, own);
                if (MH[d] != 0 && h == MH[d] && w >= 0) begin
                    own = w; last = w; h = 1;
                end else if (MH[d] != 0 && h < MH[d]) begin
                    h = h + 1;
                end
            end
            m_own[d]  <= own;
            m_last[d] <= last;
            m_h[d]    <= h;
        end
    end

    // ---------------- checking helpers ----------------
    task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b, expected %b", nm, act, exp);
        end
    endtask

    function automatic logic [1:0] enc(input logic [3:0] g);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 0; i < 4; i++) if (g[i]) r = 2'(i);
        return r;
    endfunction

    task automatic chk_all(input string nm, input int d, input logic [3:0] exp);
        chk({nm, ".grant"}, gv[d], exp);
        chk({nm, ".valid"}, {3'b000, vv[d]}, {3'b000, |exp});
        chk({nm, ".idx"}, {2'b00, iv[d]}, {2'b00, enc(exp)});
        checks++;
        if (!$onehot0(gv[d])) begin
            errors++;
            $display("FAIL %s.onehot: got %b, expected at most one bit", nm, gv[d]);
        end
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        int         d;
        bit         rst;
        logic [3:0] rq;
        logic [3:0] exp;
        string      nm;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input int d, input bit r, input logic [3:0] q,
                       input logic [3:0] e, input string nm);
        vec_t v;
        v.d = d; v.rst = r; v.rq = q; v.exp = e; v.nm = nm;
        tbl.push_back(v);
    endtask

    int wcnt[4];

    initial begin
        reset = 1'b1;
        rq    = '0;

        // N=4 sticky: reset, rotation, wrap-around, mid-grant reset, simultaneous hand-off
        add(0, 1, 4'b1111, 4'b0000, "rst_a");
        add(0, 1, 4'b1111, 4'b0000, "rst_b");
        add(0, 0, 4'b1111, 4'b0001, "first");
        add(0, 0, 4'b1111, 4'b0001, "sticky");
        add(0, 0, 4'b1110, 4'b0010, "drop0");
        add(0, 0, 4'b1100, 4'b0100, "drop1");
        add(0, 0, 4'b1000, 4'b1000, "drop2");
        add(0, 0, 4'b1000, 4'b1000, "only3");
        add(0, 0, 4'b0000, 4'b0000, "idle");
        add(0, 0, 4'b0101, 4'b0001, "wrap");
        add(0, 0, 4'b0101, 4'b0001, "wrap_keep");
        add(0, 0, 4'b0100, 4'b0100, "to2");
        add(0, 1, 4'b1111, 4'b0000, "midrst");
        add(0, 0, 4'b1111, 4'b0001, "after_rst");
        add(0, 0, 4'b0001, 4'b0001, "keep0");
        add(0, 0, 4'b1000, 4'b1000, "swap_edge");
        add(0, 0, 4'b0111, 4'b0001, "rel_wrap");
        add(0, 0, 4'b0000, 4'b0000, "idle2");
        // N=4 hold limit 4: alternate every 4 cycles, lone requester holds
        for (int i = 0; i < 4; i++) add(1, 0, 4'b0011, 4'b0001, "hold_a");
        for (int i = 0; i < 4; i++) add(1, 0, 4'b0011, 4'b0010, "hold_b");
        for (int i = 0; i < 2; i++) add(1, 0, 4'b0011, 4'b0001, "hold_a2");
        for (int i = 0; i < 6; i++) add(1, 0, 4'b0001, 4'b0001, "hold_solo");
        add(1, 0, 4'b0000, 4'b0000, "hold_idle");
        // N=2 sticky regression
        add(2, 0, 4'b0001, 4'b0001, "n2_a");
        add(2, 0, 4'b0011, 4'b0001, "n2_ab");
        add(2, 0, 4'b0010, 4'b0010, "n2_b");
        add(2, 0, 4'b0011, 4'b0010, "n2_ba");
        add(2, 0, 4'b0000, 4'b0000, "n2_idle");

        @(negedge clock);
        foreach (tbl[t]) begin
            reset       = tbl[t].rst;
            rq[tbl[t].d] = tbl[t].rq;
            @(posedge clock);
            @(negedge clock);
            chk_all(tbl[t].nm, tbl[t].d, tbl[t].exp);
        end

        // ---------------- random phase against the model ----------------
        reset = 1'b1;
        rq    = '0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) wcnt[i] = 0;
        for (int c = 0; c < 2000; c++) begin
            @(posedge clock);
            @(negedge clock);
            for (int d = 0; d < 3; d++) begin
                logic [3:0] eg;
                eg = (m_own[d] < 0) ? 4'b0000 : 4'(1 << m_own[d]);
                chk_all($sformatf("rnd%0d.c%0d", d, c), d, eg);
            end
            // Continuous waiting on the hold-limited instance must stay bounded.
            for (int i = 0; i < 4; i++) begin
                if (reset || gv[1][i] || !rq[1][i]) wcnt[i] = 0;
                else wcnt[i] = wcnt[i] + 1;
                checks++;
                if (wcnt[i] > FAIR) begin
                    errors++;
                    $display("FAIL fair.req%0d: waited %0d cycles, limit %0d", i, wcnt[i], FAIR);
                end
            end
            reset = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 2) == 0) rq[0] = 4'($urandom);
            rq[1] = 4'($urandom) | 4'($urandom);
            if ($urandom_range(0, 2) == 0) rq[2] = {2'b00, 2'($urandom)};
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
